// File: rtl/vc_flit_buffer_pkg.sv
// rtl/vc_flit_buffer_pkg.sv - shared constants and helpers for vc_flit_buffer
package vc_flit_buffer_pkg;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_UNDERFLOW = 1;

  function automatic int clogb(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vc_flit_buffer_if.sv
// rtl/vc_flit_buffer_if.sv - push/pop/status bundle between decoder, buffer and arbiter
interface vc_flit_buffer_if #(
  parameter int num_vcs = 8,
  parameter int flit_data_width = 64
);
  logic                       push_active;
  logic                       push_valid;
  logic [num_vcs-1:0]         push_sel_ivc;
  logic                       push_head;
  logic                       push_tail;
  logic [flit_data_width-1:0] push_data;
  logic                       pop_active;
  logic                       pop_valid;
  logic [num_vcs-1:0]         pop_sel_ivc;
  logic [flit_data_width-1:0] pop_data;
  logic [num_vcs-1:0]         pop_tail_ivc;
  logic [num_vcs-1:0]         empty_ivc;
  logic [num_vcs-1:0]         almost_empty_ivc;
  logic [num_vcs-1:0]         full_ivc;
  logic [2*num_vcs-1:0]       errors_ivc;

  modport master (
    output push_active, push_valid, push_sel_ivc, push_head, push_tail, push_data,
    output pop_active, pop_valid, pop_sel_ivc,
    input  pop_data, pop_tail_ivc, empty_ivc, almost_empty_ivc, full_ivc, errors_ivc
  );

  modport slave (
    input  push_active, push_valid, push_sel_ivc, push_head, push_tail, push_data,
    input  pop_active, pop_valid, pop_sel_ivc,
    output pop_data, pop_tail_ivc, empty_ivc, almost_empty_ivc, full_ivc, errors_ivc
  );
endinterface

// File: rtl/vc_flit_buffer_vc_fifo_ctrl.sv
// rtl/vc_flit_buffer_vc_fifo_ctrl.sv - pointer/count/status control for one VC circular FIFO
module vc_fifo_ctrl
  import vc_flit_buffer_pkg::*;
#(
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  output logic                     wr_en,
  output logic [clogb(depth)-1:0]  wr_ptr,
  output logic [clogb(depth)-1:0]  rd_ptr,
  output logic [clogb(depth):0]    count,
  output logic                     empty,
  output logic                     almost_empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int ptr_w = clogb(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

  logic do_pop;

  // A full FIFO still takes a push when the same cycle frees its head entry.
  assign do_pop       = pop && (count != '0);
  assign wr_en        = push && ((count != full_cnt) || do_pop);
  assign empty        = (count == '0);
  assign almost_empty = (count == cnt_w'(1));
  assign full         = (count == full_cnt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + ptr_w'(1);
      if (do_pop) rd_ptr <= rd_ptr + ptr_w'(1);
      count     <= count + cnt_w'(wr_en) - cnt_w'(do_pop);
      overflow  <= push && !wr_en;
      underflow <= pop && !do_pop;
    end
  end
endmodule

// File: rtl/vc_flit_buffer.sv
// rtl/vc_flit_buffer.sv - per-VC statically partitioned flit buffer; VC_FLIT_BUFFER_BYPASS_EN enables empty-VC bypass
module vc_flit_buffer
  import vc_flit_buffer_pkg::*;
#(
  parameter int num_vcs = 8,
  parameter int buffer_size = 64,
  parameter int flit_data_width = 64
) (
  input logic           clk,
  input logic           reset,
  vc_flit_buffer_if.slave bus
);
  localparam int depth = buffer_size / num_vcs;
  localparam int ptr_w = clogb(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam int idx_w = (num_vcs > 1) ? clogb(num_vcs) : 1;

  logic [num_vcs-1:0] push_oh, pop_oh, push_req, pop_req, bypass;
  logic [num_vcs-1:0] ctrl_push, ctrl_pop, wr_en, ovf, unf, empty, aempty, full;
  logic [num_vcs-1:0][ptr_w-1:0] wr_ptr, rd_ptr;
  logic [num_vcs-1:0][cnt_w-1:0] count;
  logic [num_vcs-1:0][flit_data_width:0] head_word;
  logic [idx_w-1:0] pop_idx;
  logic unused_head;

  assign unused_head = bus.push_head;

  // Multi-hot selects collapse to their lowest set bit.
  assign push_oh  = bus.push_sel_ivc & (~bus.push_sel_ivc + num_vcs'(1));
  assign pop_oh   = bus.pop_sel_ivc & (~bus.pop_sel_ivc + num_vcs'(1));
  assign push_req = push_oh & {num_vcs{bus.push_active & bus.push_valid}};
  assign pop_req  = pop_oh & {num_vcs{bus.pop_active & bus.pop_valid}};

`ifdef VC_FLIT_BUFFER_BYPASS_EN
  always_comb begin
    bypass = '0;
    for (int v = 0; v < num_vcs; v++) begin
      bypass[v] = push_req[v] & pop_req[v] & (count[v] == '0);
    end
  end
`else
  assign bypass = '0;
`endif

  assign ctrl_push = push_req & ~bypass;
  assign ctrl_pop  = pop_req & ~bypass;

  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    logic [flit_data_width:0] mem [depth];

    vc_fifo_ctrl #(.depth(depth)) u_ctrl (
      .clk          (clk),
      .reset        (reset),
      .push         (ctrl_push[v]),
      .pop          (ctrl_pop[v]),
      .wr_en        (wr_en[v]),
      .wr_ptr       (wr_ptr[v]),
      .rd_ptr       (rd_ptr[v]),
      .count        (count[v]),
      .empty        (empty[v]),
      .almost_empty (aempty[v]),
      .full         (full[v]),
      .overflow     (ovf[v]),
      .underflow    (unf[v])
    );

    always_ff @(posedge clk) begin
      if (wr_en[v]) mem[wr_ptr[v]] <= {bus.push_tail, bus.push_data};
    end

    assign head_word[v] = mem[rd_ptr[v]];
  end

  always_comb begin
    pop_idx = '0;
    for (int v = num_vcs - 1; v >= 0; v--) begin
      if (bus.pop_sel_ivc[v]) pop_idx = idx_w'(v);
    end
  end

  always_comb begin
    bus.pop_data = bypass[pop_idx] ? bus.push_data : head_word[pop_idx][flit_data_width-1:0];
    bus.pop_tail_ivc = '0;
    bus.errors_ivc   = '0;
    for (int v = 0; v < num_vcs; v++) begin
      bus.pop_tail_ivc[v] = bypass[v] ? bus.push_tail
                                      : ((count[v] != '0) & head_word[v][flit_data_width]);
      bus.errors_ivc[2*v+ERR_OVERFLOW]  = ovf[v];
      bus.errors_ivc[2*v+ERR_UNDERFLOW] = unf[v];
    end
  end

  assign bus.empty_ivc        = empty;
  assign bus.almost_empty_ivc = aempty;
  assign bus.full_ivc         = full;
endmodule

// File: tb/tb_vc_flit_buffer.sv
// tb/tb_vc_flit_buffer.sv - scoreboard bench for vc_flit_buffer against a queue-per-VC model
module tb_vc_flit_buffer;
  localparam int NV = 8;
  localparam int BS = 64;
  localparam int W  = 64;
  localparam int D  = BS / NV;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_flit_buffer_if #(.num_vcs(NV), .flit_data_width(W)) bus ();

  vc_flit_buffer #(.num_vcs(NV), .buffer_size(BS), .flit_data_width(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NV-1:0]   empty;
    logic [NV-1:0]   almost;
    logic [NV-1:0]   full;
    logic [NV-1:0]   tail;
    logic [2*NV-1:0] err;
    bit              has_data;
    logic [W-1:0]    data;
  } exp_t;

  exp_t         sb[$];
  exp_t         me;
  logic [W:0]   q[NV][$];
  logic [2*NV-1:0] err_next = '0;
  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int lowest(input logic [NV-1:0] s);
    for (int i = 0; i < NV; i++) if (s[i]) return i;
    return -1;
  endfunction

  // One clock of stimulus; records what the DUT must show this cycle, then advances the model.
  task automatic cycle(input bit rst, input bit pa, input bit pv, input logic [NV-1:0] ps,
                       input bit pt, input logic [W-1:0] pd,
                       input bit qa, input bit qv, input logic [NV-1:0] qs);
    exp_t e;
    int pi, qi, si;
    bit byp, pop_ok, push_ok;
    @(posedge clk);
    #1;
    reset            = !rst;
    bus.push_active  = pa;
    bus.push_valid   = pv;
    bus.push_sel_ivc = ps;
    bus.push_head    = $urandom_range(0, 1);
    bus.push_tail    = pt;
    bus.push_data    = pd;
    bus.pop_active   = qa;
    bus.pop_valid    = qv;
    bus.pop_sel_ivc  = qs;
    pi = (pa && pv) ? lowest(ps) : -1;
    qi = (qa && qv) ? lowest(qs) : -1;
    byp = 0;
`ifdef VC_FLIT_BUFFER_BYPASS_EN
    if (pi >= 0 && pi == qi && q[pi].size() == 0) byp = 1;
`endif
    for (int v = 0; v < NV; v++) begin
      e.empty[v]  = (q[v].size() == 0);
      e.almost[v] = (q[v].size() == 1);
      e.full[v]   = (q[v].size() == D);
      e.tail[v]   = (q[v].size() > 0) ? q[v][0][W] : 1'b0;
    end
    e.err = err_next;
    si = lowest(qs);
    if (si < 0) si = 0;
    e.has_data = 0;
    e.data = '0;
    if (byp) begin
      e.tail[pi] = pt;
      e.has_data = 1;
      e.data = pd;
    end else if (q[si].size() > 0) begin
      e.has_data = 1;
      e.data = q[si][0][W-1:0];
    end
    sb.push_back(e);
    mon_en = 1;
    err_next = '0;
    if (rst) begin
      for (int v = 0; v < NV; v++) q[v].delete();
    end else if (!byp) begin
      pop_ok  = (qi >= 0) && (q[qi].size() > 0);
      push_ok = (pi >= 0) && ((q[pi].size() < D) || (pop_ok && qi == pi));
      if (qi >= 0 && !pop_ok) err_next[2*qi+1] = 1'b1;
      if (pi >= 0 && !push_ok) err_next[2*pi] = 1'b1;
      if (pop_ok) void'(q[qi].pop_front());
      if (push_ok) q[pi].push_back({pt, pd});
    end
  endtask

  task automatic push_only(input int vc, input bit t, input logic [W-1:0] d);
    cycle(0, 1, 1, NV'(1) << vc, t, d, 1, 0, '0);
  endtask

  task automatic pop_only(input int vc);
    cycle(0, 1, 0, '0, 0, '0, 1, 1, NV'(1) << vc);
  endtask

  task automatic idle();
    cycle(0, 1, 0, '0, 0, '0, 1, 0, '0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard: no expectation queued at %0t", $time);
      end else begin
        me = sb.pop_front();
        chk("empty_ivc", W'(bus.empty_ivc), W'(me.empty));
        chk("almost_empty_ivc", W'(bus.almost_empty_ivc), W'(me.almost));
        chk("full_ivc", W'(bus.full_ivc), W'(me.full));
        chk("errors_ivc", W'(bus.errors_ivc), W'(me.err));
        chk("pop_tail_ivc", W'(bus.pop_tail_ivc), W'(me.tail));
        if (me.has_data) chk("pop_data", bus.pop_data, me.data);
      end
    end
  end

  initial begin
    logic [NV-1:0] ps, qs;
    int ph, pop_pct;
    reset = 1'b0;
    bus.push_active = 0; bus.push_valid = 0; bus.push_sel_ivc = '0; bus.push_head = 0;
    bus.push_tail = 0; bus.push_data = '0;
    bus.pop_active = 0; bus.pop_valid = 0; bus.pop_sel_ivc = '0;
    repeat (2) @(posedge clk);

    idle();
    for (int i = 1; i <= 3; i++) push_only(2, i == 3, W'(i));
    idle();
    for (int i = 0; i < 3; i++) pop_only(2);
    idle();

    for (int i = 0; i < D; i++) push_only(0, i == D - 1, W'(64'h100 + i));
    push_only(0, 0, W'(64'h1FF));
    idle();
    for (int i = 0; i < 5; i++)
      cycle(0, 1, 1, NV'(1), i[0], W'(64'h200 + i), 1, 1, NV'(1));
    for (int i = 0; i < D + 1; i++) pop_only(0);
    idle();

    cycle(0, 1, 1, NV'(1) << 5, 1, W'(64'hAB), 1, 1, NV'(1) << 5);
    idle();
    pop_only(5);
    idle();

    push_only(1, 0, W'(64'h11));
    push_only(3, 0, W'(64'h31));
    cycle(0, 1, 1, NV'(1) << 1, 1, W'(64'h12), 1, 1, NV'(1) << 3);
    push_only(3, 1, W'(64'h32));
    cycle(1, 1, 0, '0, 0, '0, 1, 0, '0);
    idle();

    for (int i = 0; i < 3000; i++) begin
      ph = (i / 500) % 3;
      pop_pct = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
      case ($urandom_range(0, 15))
        0: ps = '0;
        1: ps = NV'($urandom);
        2: ps = NV'(1) << $urandom_range(0, NV - 1);
        default: ps = NV'(1) << $urandom_range(0, 3);
      endcase
      case ($urandom_range(0, 15))
        0: qs = '0;
        1: qs = NV'($urandom);
        2: qs = NV'(1) << $urandom_range(0, NV - 1);
        default: qs = NV'(1) << $urandom_range(0, 3);
      endcase
      cycle($urandom_range(0, 399) == 0,
            $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, ps,
            $urandom_range(0, 1), {$urandom, $urandom},
            $urandom_range(0, 7) != 0, $urandom_range(0, 99) < pop_pct, qs);
    end

    @(negedge clk);
    #1;
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vc_flit_buffer.md
Name: vc_flit_buffer

Overview:
- Input-side flit buffer for a router/sink port. Statically partitions `buffer_size` entries evenly among `num_vcs` virtual channels; each VC is a circular FIFO.
- Accepts at most one flit push and one flit pop per cycle, each to a one-hot-selected VC.
- Reports per-VC empty, almost-empty, full, head-flit tail flag, and overflow/underflow errors.
- Sits between the channel-input decoder and the VC arbiter/flow-control credit generator.

Parameters:
- num_vcs, 8: number of VCs; buffer_size/num_vcs must be a power of two ≥2.
- buffer_size, 64: total flit entries; depth per VC D = buffer_size/num_vcs.
- flit_data_width, 64: flit payload width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- push_active  in  1  push-side enable; push ignored when 0.
- push_valid  in  1  flit present this cycle.
- push_sel_ivc  in  num_vcs  one-hot target VC.
- push_head  in  1  head-flit flag (accepted, not stored).
- push_tail  in  1  tail-flit flag, stored with flit.
- push_data  in  flit_data_width  flit payload.
- pop_active  in  1  pop-side enable; pop ignored when 0.
- pop_valid  in  1  pop request this cycle.
- pop_sel_ivc  in  num_vcs  one-hot VC to pop.
- pop_data  out  flit_data_width  flit at head of selected VC (combinational).
- pop_tail_ivc  out  num_vcs  tail flag of each VC's head flit.
- empty_ivc  out  num_vcs  VC holds 0 flits.
- almost_empty_ivc  out  num_vcs  VC holds exactly 1 flit.
- full_ivc  out  num_vcs  VC holds D flits.
- errors_ivc  out  2*num_vcs  bit 2v = overflow of VC v; bit 2v+1 = underflow of VC v.

Behaviour:
- Effective push: push_active & push_valid & push_sel_ivc[v].
- Effective pop: pop_active & pop_valid & pop_sel_ivc[v].
- All-zero select means no operation. Multi-hot select is illegal; the lowest set index wins.
- Reset (reset==0 at a clock edge): all read/write pointers and counts = 0.
  - Outputs: empty_ivc all 1s; almost_empty_ivc, full_ivc, errors_ivc all 0s; pop_tail_ivc 0s.
  - Storage contents are not reset. Reset mid-operation discards all buffered flits.
- Per-VC state: wr_ptr, rd_ptr (log2 D bits, wrap D-1→0), count (0..D).
- Push to VC v with count<D, or count==D with a simultaneous pop of v:
  - write data and tail at wr_ptr; wr_ptr++.
- Pop of VC v with count>0: rd_ptr++.
- Count update: count += push − pop.
- Simultaneous push and pop on the same non-empty VC: count unchanged. Push and pop on different VCs are independent.
- pop_data = storage[selected VC][rd_ptr], combinational, same cycle as pop_valid. With no VC selected it shows VC 0's head.
- pop_tail_ivc[v] = stored tail bit at rd_ptr of v when count>0, else 0. Bypass case is described under Optional Feature.
- Status outputs empty/almost_empty/full derive from registered count: valid the cycle after the update, no combinational path from push/pop.
- Overflow: push to full VC without same-VC pop.
  - Flit dropped, state unchanged; errors_ivc[2v] = 1 for exactly the next cycle.
- Underflow: pop of empty VC not satisfied by bypass.
  - No state change; pop_data = stale storage; errors_ivc[2v+1] = 1 next cycle.
- Errors are registered, non-sticky, and cleared by reset.
- Latency:
  - A flit pushed in cycle N is poppable from storage in cycle N+1.
  - A credit-producing pop in cycle N frees the entry for a push in cycle N+1; the same-cycle full-with-pop case is allowed above.

Optional Feature:
- Macro VC_FLIT_BUFFER_BYPASS_EN.
- Defined: pop of an empty VC in the same cycle as a push to that VC is a bypass.
  - pop_data = push_data; pop_tail_ivc[v] = push_tail.
  - Nothing written; pointers and count unchanged; no error.
- Undefined: the push is written normally, the pop is an underflow (error bit set), and pop_data is stale storage.

Decomposition:
- Shared package: clogb function, error-bit index constants (ERR_OVERFLOW=0, ERR_UNDERFLOW=1 within each VC pair).
- One sub-module, vc_fifo_ctrl, instantiated num_vcs times:
  - Inputs: push, pop.
  - Outputs: wr_ptr, rd_ptr, count, empty/almost_empty/full, overflow/underflow.
- The top level holds the 2-D storage array (data+tail) and the bypass/read muxing.

Test Plan:
1. Release reset after 2 cycles of reset=0 → empty_ivc=8'hFF, full_ivc=0, errors_ivc=0.
2. Push 3 flits (data 1,2,3; tail on 3) to VC 2 over cycles 1-3, then pop VC 2 for cycles 5-7:
   - pop_data = 1,2,3 in order; pop_tail_ivc[2]=1 only with data 3; almost_empty_ivc[2]=1 after 2 pops; empty_ivc[2]=1 after the third.
3. Push 8 flits to VC 0 (D=8), then push a 9th without pop:
   - full_ivc[0]=1; errors_ivc[0]=1 for one cycle; a later drain returns exactly the first 8 flits.
4. VC 0 full, push and pop VC 0 in the same cycle → no error, count stays 8, FIFO order preserved across pointer wrap.
5. With macro defined, push data 0xAB (tail=1) and pop VC 5 while empty:
   - pop_data=0xAB and pop_tail_ivc[5]=1 in the same cycle; empty_ivc[5] stays 1; no error.
   - Without the macro: errors_ivc[11]=1 next cycle and empty_ivc[5]=0.
6. Push to VC 1 and VC 3 with interleaved pops, then assert reset mid-stream → all VCs empty next cycle, errors 0.
